rnn_seq_driver: RTL

RNN_SEQ_DRIVER -- requirements
Module: rnn_seq_driver

---
 rtl/rnn_pkg.sv | 28 ++
 rtl/emb_table.sv | 30 +++
 rtl/rnn_seq_driver.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/rnn_pkg.sv
// rtl/rnn_pkg.sv - shared constants and driver state type for the rnn sequence driver
package rnn_pkg;

    // Element index width inside one embedding and rnn input index width.
    localparam int EMB_BITS = 2;
    localparam int RNN_BITS = 5;

    // rnn register map; the status registers share offsets with the command registers.
    localparam logic [2:0] ADDR_START        = 3'd0;
    localparam logic [2:0] ADDR_INPUT        = 3'd1;
    localparam logic [2:0] ADDR_DENSE_GO     = 3'd7;
    localparam logic [2:0] ADDR_STATUS_VALID = 3'd0;
    localparam logic [2:0] ADDR_STATUS_LOAD  = 3'd1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_EMB_RD,
        ST_EMB_WR,
        ST_KICK,
        ST_WAIT_STEP,
        ST_FINISH,
        ST_POLL_VALID,
        ST_FETCH,
        ST_WAIT_LOAD,
        ST_OUT
    } drv_state_t;

endpackage

// File: rtl/emb_table.sv
// rtl/emb_table.sv - 1-write/1-read synchronous embedding RAM
//
// Ports:
//   clk           clock
//   we/waddr/wdata  write port, one word per cycle
//   raddr/rdata     read port, rdata valid one cycle after raddr
// A read of the address being written in the same cycle returns the old word.
// Contents are not reset.
module emb_table #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/rnn_seq_driver.sv
// rtl/rnn_seq_driver.sv - feeds embedded char sequences into an rnn and returns its result
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   tbl_we/tbl_addr/tbl_wdata          embedding table write port, address {char, elem}
//   in_valid/in_ready/in_char/in_last  char stream, in_last marks end of sequence
//   m_write/m_read/m_addr/m_writedata  rnn register port (registered)
//   m_readdata                         rnn read data, combinational with m_read
//   out_valid/out_ready                result handshake
//   out_result/out_class/out_timeout   signed result, ~sign, watchdog abort flag
module rnn_seq_driver
    import rnn_pkg::*;
#(
    parameter int VOCAB_BITS = 6,
    parameter int EMB_LEN    = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         tbl_we,
    input  logic [VOCAB_BITS+EMB_BITS-1:0] tbl_addr,
    input  logic [15:0]                  tbl_wdata,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [VOCAB_BITS-1:0]        in_char,
    input  logic                         in_last,
    output logic                         m_write,
    output logic                         m_read,
    output logic [2:0]                   m_addr,
    output logic [31:0]                  m_writedata,
    input  logic [31:0]                  m_readdata,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [15:0]                  out_result,
    output logic                         out_class,
    output logic                         out_timeout
);

    localparam int TBL_AW = VOCAB_BITS + EMB_BITS;
    localparam int WD_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]     WD_LAST   = WD_W'(TIMEOUT - 1);
    localparam logic [EMB_BITS-1:0] ELEM_LAST = EMB_BITS'(EMB_LEN - 1);

    drv_state_t              state;
    logic [VOCAB_BITS-1:0]   char_q;
    logic                    last_q;
    logic [EMB_BITS-1:0]     elem;
    logic [WD_W-1:0]         wdog;
    logic [15:0]             rdata;

    logic poll_hit;
    logic wd_expired;
    logic unused_readdata;

    assign poll_hit        = m_readdata[0];
    assign wd_expired      = (wdog == WD_LAST);
    assign unused_readdata = ^m_readdata[31:16];

    emb_table #(
        .AW (TBL_AW),
        .DW (16)
    ) u_table (
        .clk   (clk),
        .we    (tbl_we),
        .waddr (tbl_addr),
        .wdata (tbl_wdata),
        .raddr ({char_q, elem}),
        .rdata (rdata)
    );

    // Table data only arrives in EMB_WR, so the write payload is muxed from the
    // RAM output register rather than registered a second time.
    assign m_writedata = (state == ST_EMB_WR) ? {8'h00, 6'b0, elem, rdata} : 32'h0;

    // Outputs are registered: each transition loads the bus values of the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            char_q      <= '0;
            last_q      <= 1'b0;
            elem        <= '0;
            wdog        <= '0;
            in_ready    <= 1'b0;
            m_write     <= 1'b0;
            m_read      <= 1'b0;
            m_addr      <= 3'd0;
            out_valid   <= 1'b0;
            out_result  <= 16'h0;
            out_class   <= 1'b0;
            out_timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // in_ready lags reset release by one edge, so accept only on in_ready.
                    if (in_valid && in_ready) begin
                        char_q   <= in_char;
                        last_q   <= in_last;
                        elem     <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_EMB_RD;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end

                ST_EMB_RD: begin
                    m_write <= 1'b1;
                    m_addr  <= ADDR_INPUT;
                    state   <= ST_EMB_WR;
                end

                ST_EMB_WR: begin
                    elem <= elem + 1'b1;
                    if (elem != ELEM_LAST) begin
                        m_write <= 1'b0;
                        m_addr  <= 3'd0;
                        state   <= ST_EMB_RD;
                    end else begin
                        m_write <= 1'b1;
                        m_addr  <= ADDR_START;
                        state   <= ST_KICK;
                    end
                end

                ST_KICK: begin
                    m_write <= 1'b0;
                    m_read  <= 1'b1;
                    m_addr  <= ADDR_STATUS_LOAD;
                    wdog    <= '0;
                    state   <= ST_WAIT_STEP;
                end

                ST_WAIT_STEP: begin
                    if (poll_hit) begin
                        m_read <= 1'b0;
                        if (last_q) begin
                            m_write <= 1'b1;
                            m_addr  <= ADDR_DENSE_GO;
                            state   <= ST_FINISH;
                        end else begin
                            m_addr   <= 3'd0;
                            in_ready <= 1'b1;
                            state    <= ST_IDLE;
                        end
                    end else if (wd_expired) begin
                        m_read      <= 1'b0;
                        m_addr      <= 3'd0;
                        out_valid   <= 1'b1;
                        out_timeout <= 1'b1;
                        out_result  <= 16'h0;
                        out_class   <= 1'b0;
                        state       <= ST_OUT;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end

                ST_FINISH: begin
                    m_write <= 1'b0;
                    m_read  <= 1'b1;
                    m_addr  <= ADDR_STATUS_VALID;
                    wdog    <= '0;
                    state   <= ST_POLL_VALID;
                end

                ST_POLL_VALID: begin
                    if (poll_hit) begin
                        m_addr <= ADDR_DENSE_GO;
                        state  <= ST_FETCH;
                    end else if (wd_expired) begin
                        m_read      <= 1'b0;
                        m_addr      <= 3'd0;
                        out_valid   <= 1'b1;
                        out_timeout <= 1'b1;
                        out_result  <= 16'h0;
                        out_class   <= 1'b0;
                        state       <= ST_OUT;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end

                ST_FETCH: begin
                    out_result <= m_readdata[15:0];
                    out_class  <= ~m_readdata[15];
                    m_addr     <= ADDR_STATUS_LOAD;
                    wdog       <= '0;
                    state      <= ST_WAIT_LOAD;
                end

                // Reading the result clears the rnn; wait for its load-ready before
                // returning to IDLE so no input write lands in the clear cycle.
                ST_WAIT_LOAD: begin
                    if (poll_hit) begin
                        m_read    <= 1'b0;
                        m_addr    <= 3'd0;
                        out_valid <= 1'b1;
                        state     <= ST_OUT;
                    end else if (wd_expired) begin
                        m_read      <= 1'b0;
                        m_addr      <= 3'd0;
                        out_valid   <= 1'b1;
                        out_timeout <= 1'b1;
                        out_result  <= 16'h0;
                        out_class   <= 1'b0;
                        state       <= ST_OUT;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end

                ST_OUT: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        out_timeout <= 1'b0;
                        in_ready    <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end

                default: begin
                    m_write  <= 1'b0;
                    m_read   <= 1'b0;
                    m_addr   <= 3'd0;
                    in_ready <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
